// File: rtl/barrido_teclado.sv
// Keypad scanner/debouncer for the 4x4 hex keypad.
// Ports:
//   clk_i, reset_i (async, active high)
//   filas_i            rows, active low, async to clk_i
//   columnas_o         one-hot active-low column drive
//   cuenta_o           index of the driven column
//   dato_codificador_o encoded row of the accepted key
//   we_o               one-cycle strobe per accepted press
//   tecla_activa_o     high from accepted press to release
module barrido_teclado #(
    parameter int DIV_BARRIDO   = 10000,
    parameter int REBOTE_CICLOS = 100000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [3:0] filas_i,
    output logic [3:0] columnas_o,
    output logic [1:0] cuenta_o,
    output logic [1:0] dato_codificador_o,
    output logic       we_o,
    output logic       tecla_activa_o
);

    localparam int DW = $clog2(DIV_BARRIDO);
    localparam int RW = $clog2(REBOTE_CICLOS);

    typedef enum logic [1:0] {
        BARRIDO,
        VALIDANDO,
        PULSO,
        ESPERA_SOLTAR
    } estado_t;

    estado_t estado_q, estado_d;

    logic [3:0]    sync1_q;
    logic [3:0]    filas_s;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [RW-1:0] reb_q, reb_d;
    logic [1:0]    cuenta_q, cuenta_d;
    logic [1:0]    dato_q, dato_d;
    logic          activa_q, activa_d;
    logic [3:0]    columnas_q;

    logic [1:0] fila_cod;
    logic       any_row;
    logic       dwell_fin;
    logic       reb_fin;

    assign any_row   = ~&filas_s;
    assign dwell_fin = (dwell_q == DW'(DIV_BARRIDO - 1));
    assign reb_fin   = (reb_q == RW'(REBOTE_CICLOS - 1));

    // Lowest-index active row wins.
    always_comb begin
        fila_cod = 2'd0;
        if (!filas_s[0])
            fila_cod = 2'd0;
        else if (!filas_s[1])
            fila_cod = 2'd1;
        else if (!filas_s[2])
            fila_cod = 2'd2;
        else if (!filas_s[3])
            fila_cod = 2'd3;
    end

    always_comb begin
        estado_d = estado_q;
        dwell_d  = dwell_q;
        reb_d    = reb_q;
        cuenta_d = cuenta_q;
        dato_d   = dato_q;
        activa_d = activa_q;
        unique case (estado_q)
            BARRIDO: begin
                if (dwell_fin) begin
                    dwell_d = '0;
                    if (any_row) begin
                        estado_d = VALIDANDO;
                        dato_d   = fila_cod;
                        reb_d    = '0;
                    end else begin
                        cuenta_d = cuenta_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            VALIDANDO: begin
                // A changed or vanished row aborts and moves on.
                if (!any_row || fila_cod != dato_q) begin
                    reb_d    = '0;
                    estado_d = BARRIDO;
                    cuenta_d = cuenta_q + 2'd1;
                end else if (reb_fin) begin
                    reb_d    = '0;
                    estado_d = PULSO;
                    activa_d = 1'b1;
                end else begin
                    reb_d = reb_q + 1'b1;
                end
            end
            PULSO: begin
                reb_d    = '0;
                estado_d = ESPERA_SOLTAR;
            end
            ESPERA_SOLTAR: begin
                if (any_row) begin
                    reb_d = '0;
                end else if (reb_fin) begin
                    reb_d    = '0;
                    activa_d = 1'b0;
                    cuenta_d = cuenta_q + 2'd1;
                    estado_d = BARRIDO;
                end else begin
                    reb_d = reb_q + 1'b1;
                end
            end
            default: estado_d = BARRIDO;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q    <= 4'b1111;
            filas_s    <= 4'b1111;
            estado_q   <= BARRIDO;
            dwell_q    <= '0;
            reb_q      <= '0;
            cuenta_q   <= 2'd0;
            dato_q     <= 2'd0;
            activa_q   <= 1'b0;
            columnas_q <= 4'b1110;
        end else begin
            sync1_q    <= filas_i;
            filas_s    <= sync1_q;
            estado_q   <= estado_d;
            dwell_q    <= dwell_d;
            reb_q      <= reb_d;
            cuenta_q   <= cuenta_d;
            dato_q     <= dato_d;
            activa_q   <= activa_d;
            // Decoded from the next count so it moves with cuenta_o.
            columnas_q <= ~(4'b0001 << cuenta_d);
        end
    end

    assign columnas_o         = columnas_q;
    assign cuenta_o           = cuenta_q;
    assign dato_codificador_o = dato_q;
    assign we_o               = (estado_q == PULSO);
    assign tecla_activa_o     = activa_q;

endmodule
